ram8: RTL and testbench



---
 rtl/ram8.sv | 70 +++++++
 tb/tb_ram8.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ram8.sv
// ----------------------------------------------------------------------------
// ram8 -- eight-word register file (Hack RAM8 building block)
//
// The single write strobe `load` is fanned out through a 1-to-8 decode on
// `address`, so at most one word register is enabled per clock. The read side
// is a purely combinational 8-way word multiplexer on the same `address`.
// There is no write-through path: during the cycle a write is presented,
// `out` still shows the old contents of the addressed word.
//
// Ports:
//   clk      in   1      rising-edge clock for all storage
//   rst_n    in   1      synchronous, active-low reset; clears all eight words
//   in       in   WIDTH  write data
//   load     in   1      write enable for the word at `address`
//   address  in   3      word select for both write and read
//   out      out  WIDTH  read data: contents of word[address]
// ----------------------------------------------------------------------------
module ram8 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [2:0]       address,
    output logic [WIDTH-1:0] out
);

    // One-hot (or all-zero) per-word write enables from the load demux.
    logic [7:0]            load_en;

    // Flattened view of all eight words so the read mux can index them.
    logic [7:0][WIDTH-1:0] word_bus;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_word
            localparam logic [2:0] SEL = 3'(gi);

            logic [WIDTH-1:0] word_reg;
            logic [WIDTH-1:0] word_next;

            // Demux leg: this word sees `load` only when it is addressed.
            assign load_en[gi] = load & (address == SEL);

            // Hold unless enabled; `in` is never observed when load_en is 0,
            // so an undriven data bus cannot leak into an idle word.
            always_comb begin
                word_next = word_reg;
                if (load_en[gi]) begin
                    word_next = in;
                end
            end

            // Reset takes priority over any write in the same cycle.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else begin
                    word_reg <= word_next;
                end
            end

            assign word_bus[gi] = word_reg;
        end
    endgenerate

    // Zero-latency read straight from the stored words.
    assign out = word_bus[address];

endmodule

// File: tb/tb_ram8.sv
// ----------------------------------------------------------------------------
// tb_ram8 -- self-checking directed bench for ram8.
// Inputs are changed 1 time unit after each rising edge and outputs are
// sampled there too, away from the active edge. A small expected-contents
// array (exp_mem) is updated by hand alongside each intended write.
// ----------------------------------------------------------------------------
module tb_ram8;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in;
    logic             load;
    logic [2:0]       address;
    logic [WIDTH-1:0] out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [WIDTH-1:0] exp_mem [8];

    ram8 #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .load    (load),
        .address (address),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        load    = 1'b0;
        in      = '0;
        address = 3'd0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            exp_mem[a] = 16'h0000;
            address = 3'(a);
            #1;
            total_cnt++;
            if (out !== 16'h0000)
                $display("FAIL reset_clear addr=%0d got=%h expected=%h", a, out, 16'h0000);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_write_each();
        logic [WIDTH-1:0] v;
        load = 1'b1;
        for (int a = 0; a < 8; a++) begin
            v = 16'(16'h1111 * (a + 1));
            address = 3'(a);
            in = v;
            exp_mem[a] = v;
            tick();
        end
        load = 1'b0;
        in   = '0;
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            total_cnt++;
            if (out !== exp_mem[a])
                $display("FAIL write_each addr=%0d got=%h expected=%h", a, out, exp_mem[a]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_read_before_write();
        address = 3'd3;
        in      = 16'hBEEF;
        load    = 1'b1;
        #1;
        total_cnt++;
        if (out !== 16'h4444)
            $display("FAIL rbw_before got=%h expected=%h", out, 16'h4444);
        else
            pass_cnt++;
        tick();
        load = 1'b0;
        exp_mem[3] = 16'hBEEF;
        total_cnt++;
        if (out !== 16'hBEEF)
            $display("FAIL rbw_after got=%h expected=%h", out, 16'hBEEF);
        else
            pass_cnt++;
    endtask

    task automatic test_isolation();
        address = 3'd5;
        load    = 1'b0;
        in      = 16'hFFFF;
        for (int e = 0; e < 3; e++) begin
            tick();
            total_cnt++;
            if (out !== 16'h6666)
                $display("FAIL gate_hold edge=%0d got=%h expected=%h", e, out, 16'h6666);
            else
                pass_cnt++;
        end
        // Undriven data with load low must not disturb anything.
        in = 'x;
        tick();
        total_cnt++;
        if (out !== 16'h6666)
            $display("FAIL x_safe got=%h expected=%h", out, 16'h6666);
        else
            pass_cnt++;
        in   = 16'hA5A5;
        load = 1'b1;
        tick();
        load = 1'b0;
        exp_mem[5] = 16'hA5A5;
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            total_cnt++;
            if (out !== exp_mem[a])
                $display("FAIL isolation addr=%0d got=%h expected=%h", a, out, exp_mem[a]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_reset_priority();
        rst_n   = 1'b0;
        load    = 1'b1;
        address = 3'd2;
        in      = 16'h1234;
        tick();
        rst_n = 1'b1;
        load  = 1'b0;
        in    = '0;
        for (int a = 0; a < 8; a++) begin
            exp_mem[a] = 16'h0000;
            address = 3'(a);
            #1;
            total_cnt++;
            if (out !== 16'h0000)
                $display("FAIL reset_priority addr=%0d got=%h expected=%h", a, out, 16'h0000);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        address = 3'd7;
        load    = 1'b1;
        in      = 16'h0001;
        tick();
        total_cnt++;
        if (out !== 16'h0001)
            $display("FAIL b2b_first got=%h expected=%h", out, 16'h0001);
        else
            pass_cnt++;
        in = 16'h0002;
        tick();
        load = 1'b0;
        total_cnt++;
        if (out !== 16'h0002)
            $display("FAIL b2b_second got=%h expected=%h", out, 16'h0002);
        else
            pass_cnt++;
        // Neighbouring word must have stayed cleared.
        address = 3'd6;
        #1;
        total_cnt++;
        if (out !== 16'h0000)
            $display("FAIL b2b_neighbour got=%h expected=%h", out, 16'h0000);
        else
            pass_cnt++;
    endtask

    initial begin
        rst_n   = 1'b0;
        load    = 1'b0;
        in      = '0;
        address = 3'd0;
        #2;
        test_reset();
        test_write_each();
        test_read_before_write();
        test_isolation();
        test_reset_priority();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
